// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit with hold and misaligned-PC fault
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [63:0] NextPC,
   input  logic        InstrAccept,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [63:0] CurrentPC,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   output logic        FetchFault,
   output logic [31:0] FetchCount
);

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t state;

   // The request address is always the PC of the instruction in flight.
   assign imem_addr = CurrentPC;

   // Fetch sequencer: request, await response, hold for consumer, or park in fault.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state          <= REQ;
         CurrentPC      <= RESET_PC;
         Instruction    <= 32'h0;
         InstrValid     <= 1'b0;
         FetchFault     <= 1'b0;
         FetchCount     <= 32'h0;
         imem_req_valid <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               // req_valid is low only in the first cycle out of reset, so a
               // ready seen then is not a handshake.
               if (imem_req_valid && imem_req_ready) begin
                  imem_req_valid <= 1'b0;
                  state          <= WAIT;
               end else begin
                  imem_req_valid <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  Instruction <= imem_rsp_data;
                  InstrValid  <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (InstrAccept) begin
                  CurrentPC  <= NextPC;
                  FetchCount <= FetchCount + 32'd1;
                  InstrValid <= 1'b0;
                  if (NextPC[1:0] == 2'b00) begin
                     imem_req_valid <= 1'b1;
                     state          <= REQ;
                  end else begin
                     FetchFault <= 1'b1;
                     state      <= FAULT;
                  end
               end
            end
            FAULT: begin
               imem_req_valid <= 1'b0;
               InstrValid     <= 1'b0;
               FetchFault     <= 1'b1;
            end
            default: begin
               state <= REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [63:0] NextPC;
   logic        InstrAccept;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [63:0] CurrentPC;
   logic [31:0] Instruction;
   logic        InstrValid;
   logic        FetchFault;
   logic [31:0] FetchCount;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(64'h0)) dut (
      .CLK            (CLK),
      .Reset          (Reset),
      .NextPC         (NextPC),
      .InstrAccept    (InstrAccept),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .CurrentPC      (CurrentPC),
      .Instruction    (Instruction),
      .InstrValid     (InstrValid),
      .FetchFault     (FetchFault),
      .FetchCount     (FetchCount)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b1; NextPC = 64'h0; InstrAccept = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      step(); step();
      chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("rst_pc", CurrentPC, 64'h0);
      chk("rst_instr", {32'h0, Instruction}, 64'h0);
      chk("rst_ivalid", {63'h0, InstrValid}, 64'h0);
      chk("rst_fault", {63'h0, FetchFault}, 64'h0);
      chk("rst_count", {32'h0, FetchCount}, 64'h0);

      Reset = 1'b0;
      step();
      chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("first_addr", imem_addr, 64'h0);

      // Memory stalls the request for three cycles.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h1);
         chk("stall_addr", imem_addr, 64'h0);
         chk("stall_ivalid", {63'h0, InstrValid}, 64'h0);
      end

      // Handshake at t, response at t+1, instruction valid at t+2.
      imem_req_ready = 1'b1;
      step();
      chk("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("wait_ivalid", {63'h0, InstrValid}, 64'h0);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8B02_0020;
      step();
      imem_rsp_valid = 1'b0;
      chk("hold_ivalid", {63'h0, InstrValid}, 64'h1);
      chk("hold_instr", {32'h0, Instruction}, 64'h8B02_0020);
      chk("hold_pc", CurrentPC, 64'h0);

      // Hold without accept for five cycles; a stray response is dropped.
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_2222;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold5_ivalid", {63'h0, InstrValid}, 64'h1);
         chk("hold5_instr", {32'h0, Instruction}, 64'h8B02_0020);
         chk("hold5_pc", CurrentPC, 64'h0);
         chk("hold5_req_valid", {63'h0, imem_req_valid}, 64'h0);
      end
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;

      // Accept with aligned NextPC: request to new address next cycle.
      InstrAccept = 1'b1; NextPC = 64'h4;
      step();
      chk("acc_ivalid", {63'h0, InstrValid}, 64'h0);
      chk("acc_pc", CurrentPC, 64'h4);
      chk("acc_count", {32'h0, FetchCount}, 64'h1);
      chk("acc_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("acc_addr", imem_addr, 64'h4);

      // Accept outside HOLD is ignored.
      NextPC = 64'h100;
      step();
      chk("ign_acc_pc", CurrentPC, 64'h4);
      chk("ign_acc_count", {32'h0, FetchCount}, 64'h1);
      InstrAccept = 1'b0;

      // Second fetch, then wrap the counter on its accept.
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
      step();
      imem_rsp_valid = 1'b0;
      chk("f2_instr", {32'h0, Instruction}, 64'h1234_5678);
      chk("f2_pc", CurrentPC, 64'h4);
      force dut.FetchCount = 32'hFFFF_FFFF;
      #1;
      release dut.FetchCount;
      InstrAccept = 1'b1; NextPC = 64'h8;
      step();
      InstrAccept = 1'b0;
      chk("wrap_count", {32'h0, FetchCount}, 64'h0);
      chk("wrap_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("wrap_addr", imem_addr, 64'h8);
      chk("wrap_fault", {63'h0, FetchFault}, 64'h0);

      // Third fetch, accepted with a misaligned NextPC.
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA5A5_0001;
      step();
      imem_rsp_valid = 1'b0;
      chk("f3_instr", {32'h0, Instruction}, 64'hA5A5_0001);
      chk("f3_count", {32'h0, FetchCount}, 64'h0);
      InstrAccept = 1'b1; NextPC = 64'h0000_0000_0000_0102;
      step();
      InstrAccept = 1'b0;
      chk("flt_fault", {63'h0, FetchFault}, 64'h1);
      chk("flt_pc", CurrentPC, 64'h102);
      chk("flt_count", {32'h0, FetchCount}, 64'h1);
      chk("flt_ivalid", {63'h0, InstrValid}, 64'h0);
      chk("flt_req_valid", {63'h0, imem_req_valid}, 64'h0);
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flt_sticky", {63'h0, FetchFault}, 64'h1);
         chk("flt_no_req", {63'h0, imem_req_valid}, 64'h0);
      end
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;

      // Reset clears the fault.
      Reset = 1'b1;
      step();
      chk("clr_fault", {63'h0, FetchFault}, 64'h0);
      chk("clr_pc", CurrentPC, 64'h0);
      chk("clr_count", {32'h0, FetchCount}, 64'h0);
      Reset = 1'b0;
      step();
      chk("clr_req_valid", {63'h0, imem_req_valid}, 64'h1);

      // Reset while waiting; the late response must be dropped.
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      chk("w_req_valid", {63'h0, imem_req_valid}, 64'h0);
      Reset = 1'b1;
      step();
      chk("wr_req_valid", {63'h0, imem_req_valid}, 64'h0);
      chk("wr_ivalid", {63'h0, InstrValid}, 64'h0);
      Reset = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid = 1'b0;
      chk("stale_ivalid", {63'h0, InstrValid}, 64'h0);
      chk("stale_instr", {32'h0, Instruction}, 64'h0);
      chk("stale_req_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("stale_addr", imem_addr, 64'h0);
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      step();
      chk("nores_ivalid", {63'h0, InstrValid}, 64'h0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
      step();
      imem_rsp_valid = 1'b0;
      chk("own_ivalid", {63'h0, InstrValid}, 64'h1);
      chk("own_instr", {32'h0, Instruction}, 64'hCAFE_F00D);
      chk("own_pc", CurrentPC, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: NextPC  input  64  next PC from next-PC logic; sampled only on accept.
REQ-005 Port: InstrAccept  input  1  decode/execute consumes current instruction.
REQ-006 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-007 Port: imem_req_ready  input  1  memory accepts request.
REQ-008 Port: imem_addr  output  64  request address, equals CurrentPC.
REQ-009 Port: imem_rsp_valid  input  1  memory returns instruction word.
REQ-010 Port: imem_rsp_data  input  32  instruction word.
REQ-011 Port: CurrentPC  output  64  PC of the instruction being fetched/held.
REQ-012 Port: Instruction  output  32  held instruction word.
REQ-013 Port: InstrValid  output  1  Instruction/CurrentPC valid for consumption.
REQ-014 Port: FetchFault  output  1  sticky misaligned-PC fault.
REQ-015 Port: FetchCount  output  32  number of accepted instructions.

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD, FAULT; registered outputs only.
REQ-017 REQ: imem_req_valid=1, imem_addr=CurrentPC; on imem_req_ready -> WAIT next cycle; else stay, addr stable.
REQ-018 WAIT: imem_req_valid=0; on imem_rsp_valid capture imem_rsp_data into Instruction -> HOLD; else stay (no timeout).
REQ-019 HOLD: InstrValid=1, Instruction and CurrentPC stable until InstrAccept.
REQ-020 HOLD with InstrAccept: CurrentPC<=NextPC (full 64 bits, unmodified), FetchCount+1, InstrValid=0 next cycle.
REQ-021 HOLD accept with NextPC[1:0]==2'b00 -> REQ; NextPC[1:0]!=2'b00 -> FAULT.
REQ-022 FAULT: FetchFault=1, imem_req_valid=0, InstrValid=0; exits only via Reset.
REQ-023 InstrAccept outside HOLD SHALL be ignored (no PC update, no count).
REQ-024 imem_rsp_valid outside WAIT SHALL be ignored (stale responses dropped).
REQ-025 Minimum latency: request accepted cycle t, response at t+1, InstrValid=1 at t+2; accept at t+2 gives imem_req_valid=1 at t+3 with new addr.
REQ-026 FetchCount SHALL wrap 32'hFFFF_FFFF -> 0 without side effect.
REQ-027 Only one request outstanding; no new request until prior response captured.

Reset
REQ-028 On Reset: state=REQ, CurrentPC=RESET_PC, Instruction=0, InstrValid=0, FetchFault=0, FetchCount=0, imem_req_valid=0 during the reset cycle.
REQ-029 First cycle after Reset deasserts: imem_req_valid=1, imem_addr=RESET_PC.
REQ-030 Reset in any state (incl. WAIT, HOLD, FAULT) SHALL take priority over all other inputs that cycle; responses in flight at reset are dropped per REQ-024.

Verification
REQ-031 Reset, ready=1, rsp next cycle data 32'h8B020020, accept with NextPC=4 -> InstrValid at t+2, Instruction=32'h8B020020, CurrentPC=0 then 4, FetchCount=1.
REQ-032 imem_req_ready low 3 cycles -> imem_req_valid held 1, imem_addr constant, no state change until ready.
REQ-033 HOLD with InstrAccept=0 for 5 cycles -> Instruction/CurrentPC unchanged, InstrValid=1 throughout, no request issued.
REQ-034 Accept with NextPC=64'h0000_0000_0000_0102 -> FetchFault=1 next cycle, no further requests; Reset clears fault, CurrentPC=RESET_PC.
REQ-035 Reset asserted in WAIT, memory returns rsp one cycle after reset release -> response ignored, new request to RESET_PC issued, InstrValid stays 0 until its own response.
REQ-036 Preload FetchCount path via 2^32 accepts (or forced) -> count wraps to 0, fetch continues normally.
